demux_capture: RTL

- Sequential 1-to-4 nibble distributor. It is the inverse of the 4:1 nibble mux in the RNG datapath.
- Accepts a stream of WIDTH_4-bit values over a valid/ready handshake and writes them round-robin into four registered slots (slot 0..3, matching mux selects 2'b00..2'b11).
- Presents the assembled 4-nibble frame, held stable, until the consumer acknowledges it.
- Sits between the RNG nibble source and the per-digit/per-lane consumers.

---
 rtl/demux_capture.sv | 106 ++++++++++
 1 files changed

// File: rtl/demux_capture.sv
// Sequential 1-to-4 nibble distributor: fills four slots round-robin, then holds the frame until acked.
// Optional DEMUX_PARITY_EN adds a frame_parity output (XOR of all bits of the completed frame).
module demux_capture #(
    parameter int WIDTH_4 = 4,
    parameter int WIDTH_2 = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic [WIDTH_4-1:0] in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH_4-1:0] out_1,
    output logic [WIDTH_4-1:0] out_2,
    output logic [WIDTH_4-1:0] out_3,
    output logic [WIDTH_4-1:0] out_4,
    output logic [WIDTH_2-1:0] fill_sel,
    output logic               frame_valid,
    input  logic               frame_ack
`ifdef DEMUX_PARITY_EN
    ,
    output logic               frame_parity
`endif
);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [3:0][WIDTH_4-1:0]  slot_q, slot_d;
    logic [WIDTH_2-1:0]       sel_q, sel_d;
`ifdef DEMUX_PARITY_EN
    logic                     parity_q, parity_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FILL;
            slot_q   <= '0;
            sel_q    <= '0;
`ifdef DEMUX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            sel_q    <= sel_d;
`ifdef DEMUX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // clear overrides everything, including a transfer or ack on the same edge
    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        sel_d    = sel_q;
`ifdef DEMUX_PARITY_EN
        parity_d = parity_q;
`endif
        if (clear) begin
            state_d  = FILL;
            slot_d   = '0;
            sel_d    = '0;
`ifdef DEMUX_PARITY_EN
            parity_d = 1'b0;
`endif
        end else begin
            case (state_q)
                FILL: begin
                    if (in_valid) begin
                        slot_d[sel_q] = in_data;
                        sel_d         = sel_q + 1'b1;
                        if (sel_q == '1) begin
                            state_d  = HOLD;
`ifdef DEMUX_PARITY_EN
                            parity_d = ^{slot_q[2:0], in_data};
`endif
                        end
                    end
                end
                HOLD: begin
                    if (frame_ack) begin
                        state_d = FILL;
                    end
                end
                default: state_d = FILL;
            endcase
        end
    end

    assign in_ready     = (state_q == FILL);
    assign frame_valid  = (state_q == HOLD);
    assign fill_sel     = sel_q;
    assign out_1        = slot_q[0];
    assign out_2        = slot_q[1];
    assign out_3        = slot_q[2];
    assign out_4        = slot_q[3];
`ifdef DEMUX_PARITY_EN
    assign frame_parity = parity_q;
`endif

endmodule
